// File: rtl/ssd_bin2bcd_if.sv
// Display-value bus between the CPU display path (master) and the
// binary-to-BCD converter (slave).
interface ssd_bin2bcd_if #(
  parameter int WIDTH  = 13,
  parameter int DIGITS = 4
);
  logic [WIDTH-1:0]    num;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   blank;
  logic                busy;
  logic                update;

  modport master (output num, input bcd, blank, busy, update);
  modport slave  (input num, output bcd, blank, busy, update);
endinterface

// File: rtl/ssd_bin2bcd.sv
// Sequential binary-to-BCD converter feeding the seven-segment driver.
// Re-converts the display word whenever it changes (double-dabble, one bit
// per cycle) and updates bcd/blank atomically when a conversion completes.
//
// state | meaning
// IDLE  | waiting for num to differ from last_num (or a forced first pass)
// SHIFT | one add-3/shift step per cycle, WIDTH steps total
// DONE  | publish accumulator to bcd/blank, pulse update
module ssd_bin2bcd #(
  parameter int WIDTH  = 13,
  parameter int DIGITS = 4
) (
  input logic         clk,
  input logic         rst,
  ssd_bin2bcd_if.slave bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] bin_sr;
  logic [WIDTH-1:0] last_num;
  logic [BW-1:0]    acc;
  logic [BW-1:0]    acc_adj;
  logic [BW-1:0]    bcd_q;
  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_nxt;
  logic [CW-1:0]    bit_cnt;
  logic             force_q;
  logic             busy_q;
  logic             update_q;
  logic             zero_above;

  // Add 3 to every BCD nibble that would overflow past 9 after the shift.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Leading-zero mask: a nibble blanks only if it and every higher nibble
  // is zero; the ones digit is never blanked so "0" stays visible.
  always_comb begin
    blank_nxt  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above & (acc[4*i +: 4] == 4'd0);
      blank_nxt[i] = zero_above;
    end
  end

  // Conversion FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bin_sr   <= '0;
      last_num <= '0;
      acc      <= '0;
      bcd_q    <= '0;
      blank_q  <= {{(DIGITS-1){1'b1}}, 1'b0};
      bit_cnt  <= '0;
      force_q  <= 1'b1;
      busy_q   <= 1'b0;
      update_q <= 1'b0;
    end else begin
      update_q <= 1'b0;
      case (state)
        IDLE: begin
          if (force_q || (bus.num != last_num)) begin
            bin_sr   <= bus.num;
            last_num <= bus.num;
            acc      <= '0;
            bit_cnt  <= '0;
            force_q  <= 1'b0;
            busy_q   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {acc, bin_sr} <= {acc_adj, bin_sr} << 1;
          bit_cnt       <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          bcd_q    <= acc;
          blank_q  <= blank_nxt;
          update_q <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bcd    = bcd_q;
  assign bus.blank  = blank_q;
  assign bus.busy   = busy_q;
  assign bus.update = update_q;

endmodule

// File: tb/tb_ssd_bin2bcd.sv
// Self-checking bench for ssd_bin2bcd: arithmetic reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_ssd_bin2bcd;
  localparam int WIDTH  = 13;
  localparam int DIGITS = 4;
  localparam int LAT    = WIDTH + 2;  // negedges from driving num to seeing update

  logic clk;
  logic rst;
  logic [WIDTH-1:0] num;

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt = 0;
  int upd_cnt  = 0;

  ssd_bin2bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();
  assign bus.num = num;

  ssd_bin2bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] blank_of(input int v);
    logic [3:0] b;
    int p;
    b = '0;
    p = 10;
    for (int i = 1; i < DIGITS; i++) begin
      b[i] = (v < p);
      p = p * 10;
    end
    return b;
  endfunction

  logic [15:0] m_bcd;
  logic [3:0]  m_blank;
  logic        m_busy, m_upd, m_force;
  int          m_last, m_val, m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_bcd = '0; m_blank = 4'b1110; m_busy = 0; m_upd = 0;
      m_force = 1; m_last = 0; m_left = 0; m_val = 0;
    end else begin
      m_upd = 0;
      if (m_left == 0) begin
        if (m_force || int'(num) != m_last) begin
          m_force = 0; m_last = int'(num); m_val = int'(num);
          m_left = WIDTH + 1; m_busy = 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_bcd = to_bcd(m_val); m_blank = blank_of(m_val);
          m_busy = 0; m_upd = 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, plus activity counters.
  always @(negedge clk) begin
    check("model_bcd",    32'(bus.bcd),    32'(m_bcd));
    check("model_blank",  32'(bus.blank),  32'(m_blank));
    check("model_busy",   32'(bus.busy),   32'(m_busy));
    check("model_update", 32'(bus.update), 32'(m_upd));
    if (bus.busy === 1'b1)   busy_cnt++;
    if (bus.update === 1'b1) upd_cnt++;
  end

  // ---------------- directed helpers ----------------
  task automatic wait_update(output int lat);
    lat = 0;
    do begin
      @(negedge clk); #1;
      lat++;
    end while (bus.update !== 1'b1 && lat < 60);
    if (bus.update !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL update_timeout: got no update within %0d cycles", lat);
    end
  endtask

  task automatic convert(input int v, input logic [15:0] exp_bcd, input logic [3:0] exp_blank);
    int lat;
    num = WIDTH'(v);
    busy_cnt = 0; upd_cnt = 0;
    wait_update(lat);
    check($sformatf("lat_%0d", v),   32'(lat),       32'(LAT));
    check($sformatf("bcd_%0d", v),   32'(bus.bcd),   32'(exp_bcd));
    check($sformatf("blank_%0d", v), 32'(bus.blank), 32'(exp_blank));
    check($sformatf("busy_%0d", v),  32'(busy_cnt),  32'(WIDTH + 1));
    check($sformatf("upd_%0d", v),   32'(upd_cnt),   32'd1);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    num = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_bcd",   32'(bus.bcd),   32'h0);
    check("rst_blank", 32'(bus.blank), 32'b1110);
    check("rst_busy",  32'(bus.busy),  32'h0);
    rst = 1'b0;
    busy_cnt = 0; upd_cnt = 0;

    // forced first conversion of zero
    wait_update(lat);
    check("first_lat",   32'(lat),       32'(LAT));
    check("first_bcd",   32'(bus.bcd),   32'h0000);
    check("first_blank", 32'(bus.blank), 32'b1110);
    check("first_upd",   32'(upd_cnt),   32'd1);

    convert(1234, 16'h1234, 4'b0000);
    convert(8191, 16'h8191, 4'b0000);
    convert(7,    16'h0007, 4'b1110);
    convert(40,   16'h0040, 4'b1100);

    // constant num: no activity
    busy_cnt = 0; upd_cnt = 0;
    repeat (100) @(negedge clk);
    #1;
    check("hold_busy", 32'(busy_cnt), 32'd0);
    check("hold_upd",  32'(upd_cnt),  32'd0);
    check("hold_bcd",  32'(bus.bcd),  32'h0040);

    // change during conversion is deferred, not lost
    busy_cnt = 0; upd_cnt = 0;
    num = WIDTH'(100);
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    check("mid_hold_bcd", 32'(bus.bcd), 32'h0040);
    num = WIDTH'(9);
    wait_update(lat);
    check("defer_bcd1", 32'(bus.bcd), 32'h0100);
    wait_update(lat);
    check("defer_bcd2",   32'(bus.bcd),   32'h0009);
    check("defer_blank2", 32'(bus.blank), 32'b1110);
    repeat (20) @(negedge clk);
    #1;
    check("defer_upds", 32'(upd_cnt), 32'd2);

    // async reset mid-conversion
    num = WIDTH'(4321);
    @(posedge clk);
    repeat (7) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_bcd",   32'(bus.bcd),   32'h0);
    check("abort_busy",  32'(bus.busy),  32'h0);
    check("abort_blank", 32'(bus.blank), 32'b1110);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    wait_update(lat);
    check("restart_lat", 32'(lat),     32'(LAT));
    check("restart_bcd", 32'(bus.bcd), 32'h4321);

    // randomized traffic with occasional async resets
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) num = WIDTH'($urandom_range(0, 8191));
        else                           num = WIDTH'($urandom_range(0, 120));
      end
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
      end
    end

    // settle and confirm the final value was converted
    begin
      int n = 0;
      while ((m_left != 0 || m_force || m_last != int'(num) || bus.busy) && n < 100) begin
        @(negedge clk); #1;
        n++;
      end
      @(negedge clk); #1;
      check("final_bcd",   32'(bus.bcd),   32'(to_bcd(int'(num))));
      check("final_blank", 32'(bus.blank), 32'(blank_of(int'(num))));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
